// File: rtl/mem_pkg.sv
// Shared encodings for the unified memory: access sizes, FSM states and the
// alignment check used by the access path.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Illegal size, or a half/word access not on its natural boundary.
  function automatic logic size_lane_err(input logic [1:0] size, input logic [1:0] lane);
    return (size == SZ_ILL) ||
           ((size == SZ_HALF) && lane[0]) ||
           ((size == SZ_WORD) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts and extends load data, merges store
// data into the addressed lanes of the old word. Purely combinational.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_rdata,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_rdata  = '0;
    o_merged = i_word;
    w_byte   = i_word[{i_lane, 3'b000} +: 8];
    w_half   = i_word[{i_lane[1], 4'b0000} +: 16];
    case (i_size)
      SZ_BYTE: begin
        o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
        o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_rdata = {{16{~i_unsigned & w_half[15]}}, w_half};
        o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      SZ_WORD: begin
        o_rdata  = i_word;
        o_merged = i_wdata;
      end
      default: begin
        o_rdata  = '0;
        o_merged = i_word;
      end
    endcase
  end

endmodule

// File: rtl/param_unified_mem.sv
// Unified instruction/data memory with a fixed per-access wait, little-endian
// sub-word access, range/alignment/protection errors and a post-reset data clear.
module param_unified_mem
  import mem_pkg::*;
#(
  parameter int    DEPTH_BITS   = 8,
  parameter int    INST_WORDS   = 32,
  parameter int    LATENCY      = 1,
  parameter int    PROTECT_INST = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          NWORDS   = 1 << DEPTH_BITS;
  localparam logic [31:0] L_NWORDS = 32'(NWORDS);
  localparam logic [31:0] L_LAST   = 32'(NWORDS - 1);
  localparam logic [31:0] L_INST   = 32'(INST_WORDS);
  localparam logic [2:0]  L_LAT    = 3'(LATENCY);

  logic [31:0] r_mem [NWORDS];

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_clr_ptr;
  logic [2:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_commit;
  logic        w_clr_we;
  logic        w_a_write;
  logic [31:0] w_a_addr;
  logic [31:0] w_a_wdata;
  logic [1:0]  w_a_size;
  logic        w_a_unsigned;
  logic [DEPTH_BITS-1:0] w_idx;
  logic        w_hi_err;
  logic        w_prot_err;
  logic        w_err;
  logic [31:0] w_rd_word;
  logic [31:0] w_ld_data;
  logic [31:0] w_st_word;

  // With zero latency the access commits on the accept edge, so operands come
  // straight from the request port; otherwise from the captured copy.
  always_comb begin
    w_a_write    = r_write;
    w_a_addr     = r_addr;
    w_a_wdata    = r_wdata;
    w_a_size     = r_size;
    w_a_unsigned = r_unsigned;
    if (r_state == ST_IDLE) begin
      w_a_write    = req_write;
      w_a_addr     = req_addr;
      w_a_wdata    = req_wdata;
      w_a_size     = req_size;
      w_a_unsigned = req_unsigned;
    end
  end

  assign w_idx      = w_a_addr[DEPTH_BITS+1:2];
  assign w_hi_err   = (w_a_addr >> (DEPTH_BITS + 2)) != '0;
  assign w_prot_err = (PROTECT_INST != 0) && w_a_write &&
                      ({{(32-DEPTH_BITS){1'b0}}, w_idx} < L_INST);
  assign w_err      = size_lane_err(w_a_size, w_a_addr[1:0]) || w_hi_err || w_prot_err;
  assign w_rd_word  = r_mem[w_idx];

  mem_lane_align u_align (
    .i_word     (w_rd_word),
    .i_wdata    (w_a_wdata),
    .i_lane     (w_a_addr[1:0]),
    .i_size     (w_a_size),
    .i_unsigned (w_a_unsigned),
    .o_rdata    (w_ld_data),
    .o_merged   (w_st_word)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_clr_we    = 1'b0;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_we = (r_clr_ptr < L_NWORDS);
        if (r_clr_ptr >= L_LAST) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          if (LATENCY == 0) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt <= 3'd1) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_CLEAR;
      r_clr_ptr  <= L_INST;
      r_cnt      <= '0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= SZ_WORD;
      r_unsigned <= 1'b0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) r_clr_ptr <= r_clr_ptr + 32'd1;
      if (w_accept) begin
        r_write    <= req_write;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_cnt      <= L_LAT;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_commit) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_a_write) ? 32'd0 : w_ld_data;
      end
    end
  end

  // Array has no reset; reset only blocks writes so aborted stores are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_clr_we)
        r_mem[r_clr_ptr[DEPTH_BITS-1:0]] <= '0;
      else if (w_commit && w_a_write && !w_err)
        r_mem[w_idx] <= w_st_word;
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
